// File: rtl/freq_analysis.sv
// FAS analysis stage: squared magnitude of 16 FFT bins, two per cycle,
// reporting the strongest bin index with a one-frame pending buffer.
module freq_analysis #(
  parameter int NBIN = 16,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic [3:0]      freq,
  output logic            done,
  output logic            busy,
  output logic [31:0]     max_mag,
  output logic            ovf
);

  localparam int NP = NBIN / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [2*DW-1:0] din  [NBIN];
  logic [2*DW-1:0] work [NBIN];
  logic [2*DW-1:0] pend [NBIN];
  logic            pend_full;
  logic [2:0]      p;

  logic            sq_vld;
  logic [2:0]      sq_pair;
  logic [31:0]     sq_a;
  logic [31:0]     sq_b;
  logic [31:0]     run_mag;
  logic [3:0]      run_idx;

  logic            load_new;
  logic            load_pend;
  logic            store_pend;
  logic            drop;
  logic [31:0]     win_mag;
  logic [3:0]      win_idx;

  assign din[0]  = fft_d0;
  assign din[1]  = fft_d1;
  assign din[2]  = fft_d2;
  assign din[3]  = fft_d3;
  assign din[4]  = fft_d4;
  assign din[5]  = fft_d5;
  assign din[6]  = fft_d6;
  assign din[7]  = fft_d7;
  assign din[8]  = fft_d8;
  assign din[9]  = fft_d9;
  assign din[10] = fft_d10;
  assign din[11] = fft_d11;
  assign din[12] = fft_d12;
  assign din[13] = fft_d13;
  assign din[14] = fft_d14;
  assign din[15] = fft_d15;

  function automatic logic [31:0] mag(input logic [2*DW-1:0] w);
    logic signed [31:0] re;
    logic signed [31:0] im;
    logic signed [31:0] r2;
    logic signed [31:0] i2;
    re = 32'(signed'(w[2*DW-1:DW]));
    im = 32'(signed'(w[DW-1:0]));
    r2 = re * re;
    i2 = im * im;
    return r2 + i2;
  endfunction

  // Frame routing between input, pending buffer and working register
  always_comb begin
    load_new   = 1'b0;
    load_pend  = 1'b0;
    store_pend = 1'b0;
    drop       = 1'b0;
    unique case (1'b1)
      state == S_IDLE: load_new = fft_valid;
      state == S_DONE: begin
        load_pend  = pend_full;
        load_new   = !pend_full && fft_valid;
        store_pend = pend_full && fft_valid;
      end
      default: begin
        store_pend = fft_valid && !pend_full;
        drop       = fft_valid && pend_full;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (fft_valid) state_nx = S_RUN;
      S_RUN:   if (p == 3'(NP - 1)) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_DONE;
      S_DONE: begin
        if (pend_full || fft_valid) state_nx = S_RUN;
        else                        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = state != S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NBIN; i++) begin
        work[i] <= '0;
        pend[i] <= '0;
      end
      pend_full <= 1'b0;
      p         <= '0;
      ovf       <= 1'b0;
    end else begin
      if (load_pend) work <= pend;
      else if (load_new) work <= din;
      if (store_pend) pend <= din;
      if (load_pend) pend_full <= fft_valid;
      else if (store_pend) pend_full <= 1'b1;
      if (load_new || load_pend) p <= '0;
      else if (state == S_RUN) p <= p + 3'd1;
      if (drop) ovf <= 1'b1;
    end
  end

  // Square stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq_vld  <= 1'b0;
      sq_pair <= '0;
      sq_a    <= '0;
      sq_b    <= '0;
    end else begin
      sq_vld  <= state == S_RUN;
      sq_pair <= p;
      sq_a    <= mag(work[{p, 1'b0}]);
      sq_b    <= mag(work[{p, 1'b1}]);
    end
  end

  // Odd bin must strictly beat even bin so ties keep the lower index
  always_comb begin
    win_mag = sq_a;
    win_idx = {sq_pair, 1'b0};
    if (sq_b > sq_a) begin
      win_mag = sq_b;
      win_idx = {sq_pair, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_mag <= '0;
      run_idx <= '0;
    end else if (sq_vld && (sq_pair == 3'd0 || win_mag > run_mag)) begin
      run_mag <= win_mag;
      run_idx <= win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done    <= 1'b0;
      freq    <= '0;
      max_mag <= '0;
    end else begin
      done <= state == S_DONE;
      if (state == S_DONE) begin
        freq    <= run_idx;
        max_mag <= run_mag;
      end
    end
  end

endmodule

// File: tb/tb_freq_analysis.sv
// Scoreboard bench for freq_analysis: directed plan cases plus random
// frames against a frame-level reference model.
module tb_freq_analysis;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fft_valid = 1'b0;
  logic [31:0] d [16];
  logic [3:0]  freq;
  logic        done;
  logic        busy;
  logic [31:0] max_mag;
  logic        ovf;

  always #5 clk = ~clk;

  freq_analysis dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
    .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
    .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .freq(freq), .done(done), .busy(busy), .max_mag(max_mag), .ovf(ovf)
  );

  typedef struct {
    int          at;
    logic [3:0]  f;
    logic [31:0] m;
  } exp_t;

  typedef logic [31:0] frame_t [16];

  exp_t   sbq[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     cur_end = -100;
  bit     pend = 0;
  frame_t pend_fr;
  bit     m_ovf = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strongest bin by plain arithmetic; first maximum wins
  function automatic exp_t ref_frame(input frame_t fr, input int at);
    exp_t   e;
    longint best;
    longint mg;
    int     re;
    int     im;
    best = -1;
    e.at = at;
    e.f = 0;
    e.m = 0;
    for (int k = 0; k < 16; k++) begin
      re = int'($signed(fr[k][31:16]));
      im = int'($signed(fr[k][15:0]));
      mg = longint'(re) * re + longint'(im) * im;
      if (mg > best) begin
        best = mg;
        e.f = 4'(k);
        e.m = 32'(mg);
      end
    end
    return e;
  endfunction

  // One cycle: model the edge the DUT will sample next, then drive it
  task automatic step(input bit v, input frame_t fr);
    int t;
    @(negedge clk);
    t = cyc + 1;
    if (pend && t == cur_end) begin
      sbq.push_back(ref_frame(pend_fr, t + 10));
      cur_end = t + 10;
      if (v) pend_fr = fr;
      else pend = 0;
    end else if (v && !pend && t >= cur_end) begin
      sbq.push_back(ref_frame(fr, t + 10));
      cur_end = t + 10;
    end else if (v && !pend) begin
      pend = 1;
      pend_fr = fr;
    end else if (v) begin
      m_ovf = 1;
    end
    fft_valid = v;
    d = fr;
  endtask

  task automatic idle(input int n);
    frame_t z;
    for (int i = 0; i < 16; i++) z[i] = '0;
    for (int i = 0; i < n; i++) step(0, z);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done=1 at cycle %0d, expected none", cyc);
      end else begin
        e = sbq.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("freq", freq, e.f);
        chk("max_mag", max_mag, e.m);
        chk("ovf_at_done", ovf, m_ovf);
      end
    end else if (sbq.size() != 0 && cyc > sbq[0].at) begin
      e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_done: none by cycle %0d, expected at %0d", cyc, e.at);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    fft_valid = 1'b0;
    sbq.delete();
    pend = 0;
    cur_end = -100;
    m_ovf = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_freq", freq, 0);
    chk("rst_max_mag", max_mag, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic frame_t zf();
    frame_t f;
    for (int i = 0; i < 16; i++) f[i] = '0;
    return f;
  endfunction

  initial begin
    frame_t fr;
    frame_t fb;
    int     n;
    for (int i = 0; i < 16; i++) d[i] = '0;
    repeat (3) @(negedge clk);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_freq", freq, 0);
    chk("init_max_mag", max_mag, 0);
    chk("init_ovf", ovf, 0);
    rst = 1'b1;
    idle(2);

    fr = zf(); fr[5] = 32'h0100_0000;
    step(1, fr); idle(14);
    fr = zf(); fr[3] = 32'h0200_0000; fr[9] = 32'h0200_0000;
    step(1, fr); idle(14);
    fr = zf(); fr[0] = 32'h7FFF_7FFF; fr[12] = 32'h8000_8000;
    step(1, fr); idle(14);
    fr = zf();
    step(1, fr); idle(14);

    fr = zf(); fr[2] = 32'h0300_0100;
    step(1, fr); idle(2);
    fb = zf(); fb[7] = 32'h0000_F000;
    step(1, fb);
    fr = zf(); fr[11] = 32'h7000_7000;
    step(1, fr);
    step(0, fr);
    chk("ovf_after_drop", ovf, 1);
    idle(24);

    fr = zf(); fr[4] = 32'h0500_0000;
    step(1, fr); idle(4);
    do_reset();
    idle(20);
    chk("post_reset_ovf", ovf, 0);

    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 16; i++) begin
        if (k % 3 == 0)
          fr[i] = {16'($urandom_range(0, 3)) - 16'd1,
                   16'($urandom_range(0, 3)) - 16'd1};
        else
          fr[i] = $urandom;
      end
      step(1, fr);
      n = (k % 7 == 0) ? $urandom_range(0, 3) : $urandom_range(8, 16);
      idle(n);
    end

    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      idle(1);
      n++;
    end
    idle(2);
    chk("drain_empty", sbq.size(), 0);
    chk("final_ovf", ovf, m_ovf);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
